mul_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit for the MIPS execute stage. It sits beside the Alu and takes the same rs/rt operands (opA/opB). It owns the HI/LO architectural registers, and their outputs feed the execute-stage result mux for MFHI/MFLO. While an operation is in flight it raises busy so the hazard unit stalls any dependent MFHI/MFLO, MTHI/MTLO or mult/div instruction.

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/md_shift_core.sv | 77 +++++++
 rtl/mul_div_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared ISA definitions for the multiply/divide unit.
// Holds the SPECIAL-opcode funct codes decoded by mul_div_unit, the shift-core
// mode type and a helper for taking the magnitude of a two's-complement word.
package mul_div_unit_pkg;

    localparam logic [5:0] FUN_MULT  = 6'b011000;
    localparam logic [5:0] FUN_MULTU = 6'b011001;
    localparam logic [5:0] FUN_DIV   = 6'b011010;
    localparam logic [5:0] FUN_DIVU  = 6'b011011;
    localparam logic [5:0] FUN_MTHI  = 6'b010001;
    localparam logic [5:0] FUN_MTLO  = 6'b010011;

    typedef enum logic {
        CoreMul,
        CoreDiv
    } core_mode_e;

    // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_shift_core.sv
// 64-bit accumulator / remainder shift register for the multiply/divide unit.
// Multiply: acc starts as {0, multiplier}; each step conditionally adds the
// multiplicand into the upper half and shifts right (shift/add).
// Divide: acc starts as {0, dividend}; each step shifts left and performs a
// restoring trial subtract of the divisor, shifting the quotient bit in at
// the bottom. After 32 steps acc = {remainder, quotient}.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   load_i     capture init_i/operand_i/mode_i and clear the upper half
//   step_i     perform one iteration
//   mode_i     CoreMul or CoreDiv
//   init_i     multiplier / dividend magnitude
//   operand_i  multiplicand / divisor magnitude
//   acc_o      current 64-bit accumulator
module md_shift_core
    import mul_div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        step_i,
    input  core_mode_e  mode_i,
    input  logic [31:0] init_i,
    input  logic [31:0] operand_i,
    output logic [63:0] acc_o
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] operand_q;
    core_mode_e  mode_q;

    logic [32:0] add_sum;
    logic [32:0] shifted_hi;
    logic [32:0] trial;
    logic [63:0] mul_next;
    logic [63:0] div_next;

    always_comb begin
        // Shift/add: the add carry becomes the new MSB after the right shift.
        add_sum  = {1'b0, acc_q[63:32]} + {1'b0, operand_q};
        mul_next = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

        // Restoring divide: partial remainder after the left shift needs 33 bits.
        shifted_hi = acc_q[63:31];
        trial      = shifted_hi - {1'b0, operand_q};
        if (shifted_hi >= {1'b0, operand_q}) begin
            div_next = {trial[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {shifted_hi[31:0], acc_q[30:0], 1'b0};
        end

        acc_d = acc_q;
        if (load_i) begin
            acc_d = {32'd0, init_i};
        end else if (step_i) begin
            acc_d = (mode_q == CoreDiv) ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q     <= 64'd0;
            operand_q <= 32'd0;
            mode_q    <= CoreMul;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                operand_q <= operand_i;
                mode_q    <= mode_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// FSM: StIdle -> StCalc (32 iterations in md_shift_core) -> StFixup -> StIdle.
// Signed ops iterate on operand magnitudes; StFixup restores signs, handles
// divide-by-zero and writes HI/LO. MTHI/MTLO write directly from StIdle.
// Optional feature: define MULDIV_FAST_MUL_EN to make MULT/MULTU a single-cycle
// multiply performed in StFixup (busy for one cycle); divide is unchanged.
// Ports:
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   start_i      issue strobe (accepted when idle and cancel_i is low)
//   md_funct_i   funct code (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   op_a_i       rs value
//   op_b_i       rt value
//   cancel_i     pipeline flush, aborts an in-flight op
//   busy_o       op in flight
//   hi_o, lo_o   HI/LO registers
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [5:0]  md_funct_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned ITERS    = 32;
    localparam logic [5:0]  LastIter = 6'(ITERS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Op attributes captured at accept.
    logic        is_mul_q;
    logic        div0_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic [31:0] op_a_q;
`ifdef MULDIV_FAST_MUL_EN
    logic [31:0] op_b_q;
    logic        signed_q;
`endif

    // Decode.
    logic is_mul, is_div, is_signed, is_mthi, is_mtlo, accept;

    always_comb begin
        is_mul    = (md_funct_i == FUN_MULT) || (md_funct_i == FUN_MULTU);
        is_div    = (md_funct_i == FUN_DIV)  || (md_funct_i == FUN_DIVU);
        is_signed = (md_funct_i == FUN_MULT) || (md_funct_i == FUN_DIV);
        is_mthi   = (md_funct_i == FUN_MTHI);
        is_mtlo   = (md_funct_i == FUN_MTLO);
        accept    = start_i && !cancel_i && (state_q == StIdle);
    end

    // Shift core.
    logic        core_load, core_step;
    core_mode_e  core_mode;
    logic [31:0] core_init, core_operand;
    logic [63:0] acc;

    always_comb begin
        core_mode    = is_div ? CoreDiv : CoreMul;
        core_init    = is_signed ? abs32(op_a_i) : op_a_i;
        core_operand = is_signed ? abs32(op_b_i) : op_b_i;
    end

    md_shift_core u_core (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (core_load),
        .step_i    (core_step),
        .mode_i    (core_mode),
        .init_i    (core_init),
        .operand_i (core_operand),
        .acc_o     (acc)
    );

    // Sign fixup / special cases, consumed in StFixup.
    logic [63:0] prod;
    logic [31:0] quot_fix, rem_fix;
    logic [31:0] fix_hi, fix_lo;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a, ext_b;
`endif

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        ext_a = {{32{signed_q & op_a_q[31]}}, op_a_q};
        ext_b = {{32{signed_q & op_b_q[31]}}, op_b_q};
        prod  = ext_a * ext_b;
`else
        prod  = neg_res_q ? (64'd0 - acc) : acc;
`endif
        quot_fix = neg_res_q ? (32'd0 - acc[31:0])  : acc[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc[63:32]) : acc[63:32];

        if (is_mul_q) begin
            fix_hi = prod[63:32];
            fix_lo = prod[31:0];
        end else if (div0_q) begin
            // Divide by zero bypasses sign fixup entirely.
            fix_hi = op_a_q;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end
    end

    // FSM next state, counter and HI/LO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
        core_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = 6'd0;
                    if (is_mthi) hi_d = op_a_i;
                    if (is_mtlo) lo_d = op_a_i;
                    if (is_div) begin
                        state_d   = StCalc;
                        core_load = 1'b1;
                    end
                    if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d   = StFixup;
`else
                        state_d   = StCalc;
                        core_load = 1'b1;
`endif
                    end
                end
            end
            StCalc: begin
                core_step = 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StFixup;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StFixup: begin
                state_d = StIdle;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts the op and leaves HI/LO at their pre-op values.
        if (cancel_i) begin
            cnt_d = 6'd0;
            if (state_q != StIdle) begin
                state_d   = StIdle;
                core_step = 1'b0;
                hi_d      = hi_q;
                lo_d      = lo_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            is_mul_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_a_q    <= 32'd0;
`ifdef MULDIV_FAST_MUL_EN
            op_b_q    <= 32'd0;
            signed_q  <= 1'b0;
`endif
        end else if (accept && (is_mul || is_div)) begin
            is_mul_q  <= is_mul;
            div0_q    <= is_div && (op_b_i == 32'd0);
            neg_res_q <= is_signed && (op_a_i[31] ^ op_b_i[31]);
            neg_rem_q <= is_signed && op_a_i[31];
            op_a_q    <= op_a_i;
`ifdef MULDIV_FAST_MUL_EN
            op_b_q    <= op_b_i;
            signed_q  <= is_signed;
`endif
        end
    end

    assign busy_o = (state_q != StIdle);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops
// checked against a plain-arithmetic model of HI/LO and busy duration.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulBusy = 1;
`else
    localparam int MulBusy = 33;
`endif
    localparam int DivBusy = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        busy;
    logic [31:0] hi, lo;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .md_funct_i (funct),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .cancel_i   (cancel),
        .busy_o     (busy),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: returns {hi, lo} for an iterative op.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            FUN_MULT:  return 64'(sa * sb);
            FUN_MULTU: return ua * ub;
            FUN_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Counts busy samples from now until busy drops; notes any HI/LO change.
    task automatic wait_idle(output int n, output bit held);
        n    = 0;
        held = 1'b1;
        while (busy !== 1'b0 && n < 100) begin
            if ({hi, lo} !== {exp_hi, exp_lo}) held = 1'b0;
            n++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble);
        logic [63:0] r;
        int          n;
        bit          held;
        r     = ref_op(f, a, b);
        funct = f;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            op_a  = $urandom;
            op_b  = $urandom;
            funct = 6'($urandom);
        end
        wait_idle(n, held);
        check_eq({tag, " busy"}, 64'(n),
                 64'((f == FUN_MULT || f == FUN_MULTU) ? MulBusy : DivBusy));
        check_eq({tag, " hold"}, 64'(held), 64'd1);
        {exp_hi, exp_lo} = r;
        check_eq({tag, " hilo"}, {hi, lo}, r);
    endtask

    task automatic run_mt(input string tag, input logic [5:0] f, input logic [31:0] a);
        funct = f;
        op_a  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (f == FUN_MTHI) exp_hi = a;
        else exp_lo = a;
        check_eq({tag, " busy"}, 64'(busy), 64'd0);
        check_eq({tag, " hilo"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int          n;
        bit          held;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [5:0]  codes [6];
        codes = '{FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO};

        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        funct  = 6'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        tick();
        tick();
        reset  = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check_eq("reset state", {31'd0, busy, hi, lo}, 64'd0);

        // Directed arithmetic cases.
        run_op("mult -2*3",  FUN_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check_eq("mult -2*3 value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", FUN_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_eq("multu value", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run_op("div -7/2", FUN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div -7/2 value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu 7/2", FUN_DIVU, 32'd7, 32'd2, 1'b0);
        check_eq("divu 7/2 value", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op("div by 0", FUN_DIV, 32'h1234_5678, 32'd0, 1'b1);
        check_eq("div by 0 value", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op("divu by 0", FUN_DIVU, 32'h8765_4321, 32'd0, 1'b1);
        run_op("div ovf", FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_eq("div ovf value", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI/MTLO preload, then cancel at busy cycle 10.
        run_mt("mthi", FUN_MTHI, 32'hDEAD_BEEF);
        run_mt("mtlo", FUN_MTLO, 32'h0BAD_F00D);
        funct = FUN_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("busy before cancel", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_eq("cancel busy", 64'(busy), 64'd0);
        check_eq("cancel hilo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);

        // Start pulse while busy is ignored.
        funct = FUN_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        funct = FUN_MTHI;
        op_a  = 32'h0000_1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(n, held);
        check_eq("ignored start busy", 64'(5 + n), 64'd33);
        check_eq("ignored start hold", 64'(held), 64'd1);
        exp_hi = 32'd2;
        exp_lo = 32'd14;
        check_eq("ignored start hilo", {hi, lo}, {exp_hi, exp_lo});

        // Back-to-back issue.
        run_op("b2b divu", FUN_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("b2b multu", FUN_MULTU, 32'd3, 32'd5, 1'b0);
        check_eq("b2b multu value", {hi, lo}, 64'd15);

        // cancel together with start in idle: nothing accepted.
        funct  = FUN_DIVU;
        op_a   = 32'd9;
        op_b   = 32'd2;
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check_eq("cancel+start busy", 64'(busy), 64'd0);
        funct = FUN_MTLO;
        op_a  = 32'h5555_AAAA;
        start = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        tick();
        check_eq("cancel+start hilo", {hi, lo}, {exp_hi, exp_lo});

        // Unknown funct is ignored.
        funct = 6'b100000;
        op_a  = 32'hFFFF_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("bad funct busy", 64'(busy), 64'd0);
        check_eq("bad funct hilo", {hi, lo}, {exp_hi, exp_lo});

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            f = codes[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            if (f == FUN_MTHI || f == FUN_MTLO) run_mt($sformatf("rand%0d mt", i), f, a);
            else run_op($sformatf("rand%0d f=%b", i, f), f, a, b, 1'b1);
        end

        // Reset mid-DIV.
        funct = FUN_DIV;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("reset mid-div", {31'd0, busy, hi, lo}, 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick();
        check_eq("after reset idle", {31'd0, busy, hi, lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
